// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared CPU definitions for the multi-cycle data-memory
//                responder: word width, latency-counter width and the
//                responder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int WORD_W = 32;

  // Counter width is fixed by the LATENCY cap of 15.
  localparam int CNT_W = 4;

  localparam logic [1:0] DM_IDLE = 2'd0;
  localparam logic [1:0] DM_BUSY = 2'd1;
  localparam logic [1:0] DM_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DM_IDLE,
    ST_BUSY = DM_BUSY,
    ST_RESP = DM_RESP
  } dm_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word array of DEPTH entries, synchronous write and
//                asynchronous read. Contents start at zero and are never
//                cleared by reset.
//  Ports       : clk     - clock
//                i_we    - write enable
//                i_idx   - word index (shared by read and write)
//                i_wdata - write data
//                o_rdata - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  // Declaration initialiser gives the time-0 zero contents without a reset.
  logic [WORD_W-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the MEM stage. Holds
//                the pipeline (ready_o low) for LATENCY wait cycles, then
//                commits the write or returns read data, flagging
//                misaligned, out-of-range and read+write requests.
//  Ports       : clk_i      - clock
//                rst_i      - synchronous active-low reset
//                MemRead_i  - read request, held until the response cycle
//                MemWrite_i - write request, held until the response cycle
//                addr_i     - byte address
//                data_i     - write data
//                data_o     - registered read data, valid in RESP
//                ready_o    - low stalls the pipeline
//                err_o      - access error, valid in RESP
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              ready_o,
  output logic              err_o
);

  localparam int              c_idx_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

  dm_state_e          r_state;
  dm_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_rd;
  logic               r_is_wr;
  logic               r_err;
  logic [c_idx_w-1:0] r_idx;
  logic [WORD_W-1:0]  r_wdata;

  logic               w_req;
  logic               w_err;
  logic               w_accept;
  logic               w_commit;
  logic               w_we;
  logic [WORD_W-1:0]  w_rdata;

  assign w_req = MemRead_i | MemWrite_i;
  assign w_err = (addr_i[1:0] != 2'b00)
               | ({2'b00, addr_i[WORD_W-1:2]} >= WORD_W'(DEPTH))
               | (MemRead_i & MemWrite_i);

  // Gated by rst_i so a reset on the commit edge drops the pending write.
  assign w_we = w_commit & r_is_wr & ~r_err & rst_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b1;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = ~w_req;
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        ready_o = 1'b0;
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_o     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_is_rd <= 1'b0;
      r_is_wr <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      data_o  <= '0;
      err_o   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_rd <= MemRead_i;
        r_is_wr <= MemWrite_i;
        r_err   <= w_err;
        r_idx   <= addr_i[c_idx_w+1:2];
        r_wdata <= data_i;
        r_cnt   <= c_cnt_load;
      end
      if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Response outputs are loaded on entry to RESP and cleared on exit.
      if (w_commit) begin
        err_o  <= r_err;
        data_o <= (r_is_rd & ~r_err) ? w_rdata : '0;
      end else if (r_state == ST_RESP) begin
        err_o  <= 1'b0;
        data_o <= '0;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (c_idx_w)
  ) u_dmem_array (
    .clk     (clk_i),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. A transaction-level
//                model turns each access into its expected per-cycle output
//                sequence; a compare process checks every cycle. A LATENCY=1
//                instance checks back-to-back occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr, wdata, dout;
  logic        rdy, err;

  logic        rd1, wr1;
  logic [31:0] addr1, wdata1, dout1;
  logic        rdy1, err1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .MemRead_i  (rd),
    .MemWrite_i (wr),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (dout),
    .ready_o    (rdy),
    .err_o      (err)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .MemRead_i  (rd1),
    .MemWrite_i (wr1),
    .addr_i     (addr1),
    .data_i     (wdata1),
    .data_o     (dout1),
    .ready_o    (rdy1),
    .err_o      (err1)
  );

  typedef struct packed {
    logic        rdy;
    logic [31:0] d;
    logic        e;
    logic        resp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;
  int          low_cycles = 0;
  int          cyc = 0;
  logic [31:0] resp_d;
  logic        resp_e;

  // Per-cycle compare against the model's expected output stream.
  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (rdy === 1'b0) low_cycles++;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (rdy !== x.rdy || dout !== x.d || err !== x.e) begin
        n_err++;
        $display("FAIL cycle %0d: got ready=%b data=%h err=%b, expected ready=%b data=%h err=%b",
                 cyc, rdy, dout, err, x.rdy, x.d, x.e);
      end
      if (x.resp) begin
        resp_d = dout;
        resp_e = err;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts just after a rising edge; returns just after the edge ending RESP.
  task automatic access(input bit do_rd, input bit do_wr, input logic [31:0] a,
                        input logic [31:0] d, input bit chg);
    exp_t        x;
    logic        e;
    logic [31:0] r;
    int          idx;
    idx = int'(a[31:2]);
    e   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH)) || (do_rd && do_wr);
    r   = 32'h0;
    if (!e && do_rd) r = model_mem[idx];
    if (!e && do_wr) model_mem[idx] = d;
    for (int i = 0; i < LAT + 1; i++) begin
      x = '{rdy: 1'b0, d: 32'h0, e: 1'b0, resp: 1'b0};
      exp_q.push_back(x);
    end
    x = '{rdy: 1'b1, d: r, e: e, resp: 1'b1};
    exp_q.push_back(x);
    rd = do_rd; wr = do_wr; addr = a; wdata = d;
    @(posedge clk); #1;
    if (chg) begin
      addr  = a ^ 32'h4;
      wdata = ~d;
    end
    repeat (LAT + 1) @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  initial begin
    int          lc0;
    logic [5:0]  pat;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'b0, rdy}, 32'h1);
    check("reset data", dout, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read.
    lc0 = low_cycles;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    check("write stall cycles", 32'(low_cycles - lc0), 32'd3);
    check("write err", {31'b0, resp_e}, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("read 0x10", resp_d, 32'hDEADBEEF);

    // Misaligned write leaves the neighbouring word intact.
    access(1'b0, 1'b1, 32'h12, 32'hCAFEF00D, 1'b0);
    check("misaligned err", {31'b0, resp_e}, 32'h1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("read 0x10 after misaligned", resp_d, 32'hDEADBEEF);

    // First out-of-range word and last in-range word.
    access(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
    check("out of range err", {31'b0, resp_e}, 32'h1);
    check("out of range data", resp_d, 32'h0);
    access(1'b0, 1'b1, 32'h1FC, 32'h600DF00D, 1'b0);
    access(1'b1, 1'b0, 32'h1FC, 32'h0, 1'b0);
    check("read last word", resp_d, 32'h600DF00D);

    // Conflicting read+write must not write.
    access(1'b1, 1'b1, 32'h30, 32'h55, 1'b0);
    check("conflict err", {31'b0, resp_e}, 32'h1);
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    check("read after conflict", resp_d, 32'h0);

    // Reset during BUSY of a write drops it.
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h1234;
    @(posedge clk); #1;
    rst_n = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    @(posedge clk); #1;
    check("mid-write reset ready", {31'b0, rdy}, 32'h1);
    check("mid-write reset data", dout, 32'h0);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("read after dropped write", resp_d, 32'h0);

    // Address changes during BUSY are ignored; back-to-back accesses.
    access(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b1);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    check("captured addr write", resp_d, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    check("changed addr untouched", resp_d, 32'h0);

    // LATENCY=1: two consecutive reads take 6 cycles, ready 0,0,1,0,0,1.
    wr1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h77;
    repeat (3) @(posedge clk);
    #1;
    wr1 = 1'b0; wdata1 = 32'h0;
    rd1 = 1'b1; addr1 = 32'h0;
    pat = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) addr1 = 32'h4;
      @(negedge clk);
      check($sformatf("lat1 ready[%0d]", i), {31'b0, rdy1}, {31'b0, pat[i]});
      if (i == 2) check("lat1 read 0x0", dout1, 32'h0);
      if (i == 5) check("lat1 read 0x4", dout1, 32'h77);
      if (i == 5) check("lat1 err", {31'b0, err1}, 32'h0);
      @(posedge clk); #1;
    end
    rd1 = 1'b0; addr1 = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
